load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage controller between execute and a word-addressed data memory.
//   Accepts one load/store at a time. Byte/half stores are read-modify-write
//   because the memory only writes whole words. Loads return sign- or
//   zero-extended data. Illegal accesses are answered with resp_err and never
//   touch memory.
//
// Ports
//   clock, reset         system clock; synchronous active-high reset
//   req_valid/req_ready  request handshake (transfer on valid && ready)
//   req_we               1 = store, 0 = load
//   req_size             00 byte, 01 half, 10 word, 11 reserved (error)
//   req_signed           loads: 1 = sign-extend, 0 = zero-extend
//   req_addr             byte address
//   req_wdata            store data (low-order bits for sub-word sizes)
//   resp_valid           one-cycle completion pulse
//   resp_rdata           extended load data, 0 for stores and errors
//   resp_err             access was not performed
//   mwr, moe             memory write / output enable
//   ma, mwd              memory word-aligned byte address / write data
//   mrd                  memory read data (combinational from ma/moe)
module load_store_unit #(
  parameter int unsigned ADDR_LIMIT = 512
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mwr,
  output logic        moe,
  output logic [31:0] ma,
  output logic [31:0] mwd,
  input  logic [31:0] mrd
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [31:0] addr_q;
  logic [31:0] wbuf_q;   // store data, replaced by the merged word after READ
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_err;
  logic [4:0]  byte_sh;
  logic [4:0]  lane_sh;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)                               req_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0])                req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00)     req_err = 1'b1;
    if (req_addr >= ADDR_LIMIT)                          req_err = 1'b1;
  end

  // Little-endian lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    byte_sh   = {addr_q[1:0], 3'b000};
    lane_sh   = (size_q == 2'b01) ? {addr_q[1], 4'b0000} : byte_sh;
    byte_lane = mrd[byte_sh +: 8];
    half_lane = addr_q[1] ? mrd[31:16] : mrd[15:0];
    case (size_q)
      2'b00:   load_val = {{24{sign_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_val = {{16{sign_q & half_lane[15]}}, half_lane};
      default: load_val = mrd;
    endcase
    lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
    merged    = (mrd & ~lane_mask) | ((wbuf_q << lane_sh) & lane_mask);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            sign_q  <= req_signed;
            addr_q  <= req_addr;
            wbuf_q  <= req_wdata;
            rdata_q <= '0;
            err_q   <= req_err;
            if (req_err)                 state <= RESP;
            else if (!req_we)            state <= READ;
            else if (req_size == 2'b10)  state <= WRITE;
            else                         state <= READ;
          end
        end
        READ: begin
          if (we_q) begin
            wbuf_q <= merged;
            state  <= WRITE;
          end else begin
            rdata_q <= load_val;
            state   <= RESP;
          end
        end
        WRITE:   state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; reset masks them in the reset cycle
  // so an aborted op can neither write memory nor respond.
  always_comb begin
    req_ready  = (state == IDLE)  && !reset;
    moe        = (state == READ)  && !reset;
    mwr        = (state == WRITE) && !reset;
    ma         = (moe || mwr) ? {addr_q[31:2], 2'b00} : '0;
    mwd        = mwr ? wbuf_q : '0;
    resp_valid = (state == RESP)  && !reset;
    resp_err   = resp_valid && err_q;
    resp_rdata = resp_valid ? rdata_q : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mwr;
  logic        moe;
  logic [31:0] ma;
  logic [31:0] mwd;
  logic [31:0] mrd;

  load_store_unit #(.ADDR_LIMIT(512)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mwr(mwr), .moe(moe), .ma(ma), .mwd(mwd), .mrd(mrd)
  );

  always #5 clock = ~clock;

  // Environment memory (what the DUT talks to)
  bit [31:0] mem [128];
  assign mrd = moe ? mem[ma[8:2]] : 32'hA5A5_A5A5;
  always @(posedge clock) if (mwr) mem[ma[8:2]] <= mwd;

  // Monitor of memory-port activity
  int          mwr_cnt = 0;
  int          moe_cnt = 0;
  logic [31:0] wr_ma   = '0;
  logic [31:0] wr_mwd  = '0;
  always @(negedge clock) begin
    if (mwr) begin
      mwr_cnt = mwr_cnt + 1;
      wr_ma   = ma;
      wr_mwd  = mwd;
    end
    if (moe) moe_cnt = moe_cnt + 1;
  end

  // Reference model: plain word array updated by byte arithmetic
  bit [31:0] ref_mem [128];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1 && addr % 2 != 0) return 1'b1;
    if (size == 2'd2 && addr % 4 != 0) return 1'b1;
    if (addr >= 512) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int unsigned nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  // Expected load value: take nbytes starting at byte offset, extend.
  function automatic logic [31:0] ref_load(input logic [1:0] size, input bit sgn,
                                           input logic [31:0] addr);
    logic [63:0] v;
    int unsigned n;
    n = nbytes(size);
    v = 64'(ref_mem[addr / 4]) / (64'd1 << (8 * (addr % 4)));
    v = v % (64'd1 << (8 * n));
    if (sgn && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v + 64'hFFFF_FFFF - (64'd1 << (8 * n)) + 1;
    return v[31:0];
  endfunction

  // Expected stored word: replace the addressed bytes one at a time.
  function automatic logic [31:0] ref_store(input logic [1:0] size, input logic [31:0] addr,
                                            input logic [31:0] wdata);
    logic [7:0] bytes [4];
    logic [31:0] w;
    logic [31:0] d;
    w = ref_mem[addr / 4];
    d = wdata;
    for (int k = 0; k < 4; k++) begin
      bytes[k] = w[7:0];
      w = w >> 8;
    end
    for (int unsigned k = 0; k < nbytes(size); k++) begin
      bytes[(addr % 4) + k] = d[7:0];
      d = d >> 8;
    end
    return {bytes[3], bytes[2], bytes[1], bytes[0]};
  endfunction

  task automatic do_op(input string tag, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    bit          e;
    int          lat;
    int          wr0, oe0;
    int          exp_lat;
    logic [31:0] exp_rd, exp_word;
    bit          got_resp;
    e        = ref_err(size, addr);
    exp_rd   = (!e && !we) ? ref_load(size, sgn, addr) : 32'h0;
    exp_word = (!e && we) ? ref_store(size, addr, wdata) : 32'h0;
    exp_lat  = e ? 1 : (!we || size == 2'd2) ? 2 : 3;
    wr0 = mwr_cnt;
    oe0 = moe_cnt;
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clock);
    check({tag, ":ready"}, 32'(req_ready), 32'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom); req_we = 1'($urandom);
    lat = 0;
    got_resp = 1'b0;
    for (int i = 0; i < 10 && !got_resp; i++) begin
      @(negedge clock);
      lat = lat + 1;
      got_resp = resp_valid;
    end
    check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ":err"}, 32'(resp_err), 32'(e));
    check({tag, ":rdata"}, resp_rdata, exp_rd);
    check({tag, ":mwr_cycles"}, 32'(mwr_cnt - wr0), (!e && we) ? 32'd1 : 32'd0);
    check({tag, ":moe_cycles"}, 32'(moe_cnt - oe0), (!e && (!we || size != 2'd2)) ? 32'd1 : 32'd0);
    if (!e && we) begin
      check({tag, ":ma"}, wr_ma, {addr[31:2], 2'b00});
      check({tag, ":mwd"}, wr_mwd, exp_word);
      ref_mem[addr / 4] = exp_word;
    end
    if (!e) check({tag, ":mem"}, mem[addr[8:2]], ref_mem[addr / 4]);
  endtask

  initial begin
    int          t_resp1, t_resp2, t_acc2;
    logic [31:0] d1, d2;
    logic [31:0] a;
    logic [1:0]  s;
    int unsigned r;
    int          wr0;
    bit          seen;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clock);
    check("rst:ready", 32'(req_ready), 32'd0);
    check("rst:resp_valid", 32'(resp_valid), 32'd0);
    check("rst:resp_err", 32'(resp_err), 32'd0);
    check("rst:resp_rdata", resp_rdata, 32'd0);
    check("rst:mem_ctl", {30'd0, mwr, moe}, 32'd0);
    check("rst:ma", ma, 32'd0);
    check("rst:mwd", mwd, 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("rst:ready_after", 32'(req_ready), 32'd1);

    // Word store / load and sub-word loads
    do_op("st_w8",   1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF);
    do_op("ld_w8",   1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    do_op("ld_sbB",  1'b0, 2'd0, 1'b1, 32'hB, 32'h0);
    check("ld_sbB:value", ref_load(2'd0, 1'b1, 32'hB), 32'hFFFFFFDE);
    do_op("ld_ubB",  1'b0, 2'd0, 1'b0, 32'hB, 32'h0);
    do_op("ld_shA",  1'b0, 2'd1, 1'b1, 32'hA, 32'h0);
    do_op("ld_uh8",  1'b0, 2'd1, 1'b0, 32'h8, 32'h0);
    do_op("st_b9",   1'b1, 2'd0, 1'b0, 32'h9, 32'h123456AA);
    check("st_b9:value", ref_mem[2], 32'hDEADAAEF);
    do_op("st_hA",   1'b1, 2'd1, 1'b0, 32'hA, 32'h00007777);
    check("st_hA:value", ref_mem[2], 32'h7777AAEF);

    // Errors
    do_op("err_h5",   1'b1, 2'd1, 1'b0, 32'h5,   32'hFFFF_FFFF);
    do_op("err_w6",   1'b0, 2'd2, 1'b0, 32'h6,   32'h0);
    do_op("err_sz3",  1'b1, 2'd3, 1'b0, 32'h8,   32'h1111_1111);
    do_op("err_w200", 1'b1, 2'd2, 1'b0, 32'h200, 32'h2222_2222);
    do_op("ok_w1fc",  1'b1, 2'd2, 1'b0, 32'h1FC, 32'h3333_3333);
    check("err:mem8", mem[2], 32'h7777AAEF);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 6);
      s = (r == 6) ? 2'd3 : 2'(r / 2);
      a = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'd1) a = a & 32'hFFFF_FFFE;
        if (s == 2'd2) a = a & 32'hFFFF_FFFC;
      end
      if ($urandom_range(0, 12) == 0) a = 32'd512 + $urandom;
      if (a < 32'd512) a = a % 32'd64;  // keep traffic dense on a few words
      do_op($sformatf("rnd%0d", n), 1'($urandom), s, 1'($urandom), a, $urandom);
    end

    // Reset in the WRITE cycle of a byte store
    wr0 = mwr_cnt;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h9; req_wdata = 32'h0000_0055;
    @(posedge clock); #1 req_valid = 1'b0;
    @(negedge clock);                       // READ
    @(posedge clock); #1 reset = 1'b1;      // WRITE cycle under reset
    @(negedge clock);
    check("rstmid:mwr", 32'(mwr), 32'd0);
    check("rstmid:resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("rstmid:ready", 32'(req_ready), 32'd1);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (resp_valid) seen = 1'b1;
    end
    check("rstmid:no_resp", 32'(seen), 32'd0);
    check("rstmid:no_write", 32'(mwr_cnt - wr0), 32'd0);
    check("rstmid:mem8", mem[2], ref_mem[2]);

    // Back-to-back loads with req_valid held high
    d1 = ref_load(2'd2, 1'b0, 32'h8);
    d2 = ref_load(2'd2, 1'b0, 32'hC);
    t_resp1 = -1; t_resp2 = -1; t_acc2 = -1;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h8;
    check("b2b:ready0", 32'(req_ready), 32'd1);
    @(posedge clock); #1 req_addr = 32'hC;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (resp_valid && t_resp1 < 0) begin
        t_resp1 = c;
        check("b2b:data1", resp_rdata, d1);
      end else if (resp_valid && t_resp2 < 0) begin
        t_resp2 = c;
        check("b2b:data2", resp_rdata, d2);
      end
      if (req_ready && req_valid && t_acc2 < 0 && t_resp1 >= 0) begin
        t_acc2 = c;
        @(posedge clock); #1 req_valid = 1'b0;
      end
    end
    check("b2b:resp1_cycle", 32'(t_resp1), 32'd2);
    check("b2b:accept2_cycle", 32'(t_acc2), 32'(t_resp1 + 1));
    check("b2b:resp_gap", 32'(t_resp2 - t_resp1), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
